// File: rtl/pattern_detector_param.sv
// Serial pattern detector: pulses out_bit for one cycle when the last PAT_LEN accepted bits equal pat.
// Optional saturating match counter is enabled by defining PATDET_COUNT_EN.
module pattern_detector_param #(
  parameter int                 PAT_LEN   = 4,
  parameter logic [PAT_LEN-1:0] PAT_RESET = {PAT_LEN{1'b1}},
  parameter int                 CNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               overlap_en,
  input  logic               clear,
`ifdef PATDET_COUNT_EN
  output logic [CNT_W-1:0]   match_count,
`endif
  output logic               out_bit
);

  localparam int                FILL_W   = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN);

  // Elaboration-only parameter sanity hook; keeps CNT_W referenced when the counter is compiled out.
  if (PAT_LEN < 2 || CNT_W < 1) begin : g_bad_param
  end

  logic [PAT_LEN-1:0] pat, pat_nxt;
  logic [PAT_LEN-1:0] hist, hist_nxt, hist_shift;
  logic [FILL_W-1:0]  fill, fill_nxt, fill_inc;
  logic               out_nxt;
  logic               hit_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pat     <= PAT_RESET;
      hist    <= '0;
      fill    <= '0;
      out_bit <= 1'b0;
    end else begin
      pat     <= pat_nxt;
      hist    <= hist_nxt;
      fill    <= fill_nxt;
      out_bit <= out_nxt;
    end
  end

  always_comb begin
    hist_shift = {hist[PAT_LEN-2:0], in_bit};
    fill_inc   = (fill == FILL_MAX) ? FILL_MAX : fill + FILL_W'(1);
    // fill gating stops the all-zero reset history from matching a zero pattern
    hit_acc    = (fill_inc == FILL_MAX) && (hist_shift == pat);

    pat_nxt  = pat;
    hist_nxt = hist;
    fill_nxt = fill;
    out_nxt  = 1'b0;

    if (pat_load) pat_nxt = pat_in;

    if (clear || pat_load) begin
      hist_nxt = '0;
      fill_nxt = '0;
    end else if (in_valid) begin
      hist_nxt = hist_shift;
      fill_nxt = (hit_acc && !overlap_en) ? '0 : fill_inc;
      out_nxt  = hit_acc;
    end
  end

`ifdef PATDET_COUNT_EN
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    count_nxt = match_count;
    if (clear) count_nxt = '0;
    else if (out_nxt && (match_count != {CNT_W{1'b1}})) count_nxt = match_count + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) match_count <= '0;
    else          match_count <= count_nxt;
  end
`endif

endmodule

// File: tb/tb_pattern_detector_param.sv
// Bench for pattern_detector_param: directed vector table, multi-cycle corner sequences, random run vs. queue model.
// Builds with or without PATDET_COUNT_EN; counter checks run only when it is defined.
module tb_pattern_detector_param;

  localparam int PAT_LEN = 4;
  localparam int CNT_W   = 2;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_bit = 1'b0;
  logic               pat_load = 1'b0;
  logic [PAT_LEN-1:0] pat_in = '0;
  logic               overlap_en = 1'b0;
  logic               clear = 1'b0;
  logic               out_bit;
`ifdef PATDET_COUNT_EN
  logic [CNT_W-1:0]   match_count;
`endif

  pattern_detector_param #(.PAT_LEN(PAT_LEN), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .pat_load   (pat_load),
    .pat_in     (pat_in),
    .overlap_en (overlap_en),
    .clear      (clear),
`ifdef PATDET_COUNT_EN
    .match_count(match_count),
`endif
    .out_bit    (out_bit)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: accepted bits since the last restart, oldest first.
  bit                 m_bits[$];
  logic [PAT_LEN-1:0] m_pat;
  logic               m_out;
  int                 m_cnt;

  typedef struct {
    logic               v;
    logic               b;
    logic               ld;
    logic [PAT_LEN-1:0] p;
    logic               ov;
    logic               cl;
    logic               e;
    string              name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_pat = {PAT_LEN{1'b1}};
    m_out = 1'b0;
    m_cnt = 0;
  endtask

  function automatic bit model_match();
    if (m_bits.size() != PAT_LEN) return 1'b0;
    for (int i = 0; i < PAT_LEN; i++)
      if (m_bits[i] != m_pat[PAT_LEN-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input logic v, input logic b, input logic ld,
                            input logic [PAT_LEN-1:0] p, input logic ov, input logic cl);
    m_out = 1'b0;
    if (ld) m_pat = p;
    if (cl) begin
      m_bits.delete();
      m_cnt = 0;
    end else if (ld) begin
      m_bits.delete();
    end else if (v) begin
      m_bits.push_back(b);
      if (m_bits.size() > PAT_LEN) void'(m_bits.pop_front());
      if (model_match()) begin
        m_out = 1'b1;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        if (!ov) m_bits.delete();
      end
    end
  endtask

  // Drive one cycle, advance the model, sample 1 time unit after the edge.
  task automatic step(input logic v, input logic b, input logic ld,
                      input logic [PAT_LEN-1:0] p, input logic ov, input logic cl);
    in_valid = v; in_bit = b; pat_load = ld; pat_in = p; overlap_en = ov; clear = cl;
    model_step(v, b, ld, p, ov, cl);
    @(posedge clk);
    #1;
`ifdef PATDET_COUNT_EN
    check("match_count_model", 32'(match_count), 32'(m_cnt));
`endif
  endtask

  task automatic bit_in(input logic b, input logic ov);
    step(1'b1, b, 1'b0, '0, ov, 1'b0);
  endtask

  task automatic add(input logic v, input logic b, input logic ld, input logic [PAT_LEN-1:0] p,
                     input logic ov, input logic cl, input logic e, input string name);
    vec_t r;
    r.v = v; r.b = b; r.ld = ld; r.p = p; r.ov = ov; r.cl = cl; r.e = e; r.name = name;
    vecs.push_back(r);
  endtask

  initial begin
    // test 1: default pattern, no overlap
    add(1,1,0,4'h0,0,0,0,"t1_b1"); add(1,1,0,4'h0,0,0,0,"t1_b2");
    add(1,1,0,4'h0,0,0,0,"t1_b3"); add(1,1,0,4'h0,0,0,1,"t1_b4_hit");
    add(1,1,0,4'h0,0,0,0,"t1_b5_restart"); add(0,1,0,4'h0,0,0,0,"t1_idle");
    // test 2: overlap
    add(0,0,0,4'h0,1,1,0,"t2_clear");
    add(1,1,0,4'h0,1,0,0,"t2_b1"); add(1,1,0,4'h0,1,0,0,"t2_b2");
    add(1,1,0,4'h0,1,0,0,"t2_b3"); add(1,1,0,4'h0,1,0,1,"t2_b4_hit");
    add(1,1,0,4'h0,1,0,1,"t2_b5_hit"); add(0,1,0,4'h0,1,0,0,"t2_idle_after_hit");
    // test 3: 1011 with and without overlap
    add(0,0,1,4'hB,1,0,0,"t3_load");
    add(1,1,0,4'h0,1,0,0,"t3o_1"); add(1,0,0,4'h0,1,0,0,"t3o_2"); add(1,1,0,4'h0,1,0,0,"t3o_3");
    add(1,1,0,4'h0,1,0,1,"t3o_4_hit"); add(1,0,0,4'h0,1,0,0,"t3o_5"); add(1,1,0,4'h0,1,0,0,"t3o_6");
    add(1,1,0,4'h0,1,0,1,"t3o_7_hit");
    add(0,0,1,4'hB,0,0,0,"t3_reload");
    add(1,1,0,4'h0,0,0,0,"t3n_1"); add(1,0,0,4'h0,0,0,0,"t3n_2"); add(1,1,0,4'h0,0,0,0,"t3n_3");
    add(1,1,0,4'h0,0,0,1,"t3n_4_hit"); add(1,0,0,4'h0,0,0,0,"t3n_5"); add(1,1,0,4'h0,0,0,0,"t3n_6");
    add(1,1,0,4'h0,0,0,0,"t3n_7_nohit");
    // test 4a: gaps do not break a match
    add(0,0,1,4'hF,0,0,0,"t4_load"); add(1,1,0,4'h0,0,0,0,"t4_b1"); add(1,1,0,4'h0,0,0,0,"t4_b2");
    add(0,0,0,4'h0,0,0,0,"t4_gap1"); add(0,1,0,4'h0,0,0,0,"t4_gap2"); add(0,0,0,4'h0,0,0,0,"t4_gap3");
    add(1,1,0,4'h0,0,0,0,"t4_b3"); add(1,1,0,4'h0,0,0,1,"t4_b4_hit");
    // test 5: load mid-stream drops the bit
    add(1,1,0,4'h0,0,0,0,"t5_b1"); add(1,1,0,4'h0,0,0,0,"t5_b2");
    add(1,1,1,4'hF,0,0,0,"t5_load_drop"); add(1,1,0,4'h0,0,0,0,"t5_n1");
    add(1,1,0,4'h0,0,0,0,"t5_n2"); add(1,1,0,4'h0,0,0,0,"t5_n3"); add(1,1,0,4'h0,0,0,1,"t5_n4_hit");
    // clear with load: pattern still loads; zero pattern needs full fill
    add(1,1,1,4'h0,0,1,0,"clr_ld"); add(1,0,0,4'h0,0,0,0,"z_1"); add(1,0,0,4'h0,0,0,0,"z_2");
    add(1,0,0,4'h0,0,0,0,"z_3"); add(1,0,0,4'h0,0,0,1,"z_4_hit");

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_out", 32'(out_bit), 0);
`ifdef PATDET_COUNT_EN
    check("reset_count", 32'(match_count), 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].b, vecs[i].ld, vecs[i].p, vecs[i].ov, vecs[i].cl);
      check(vecs[i].name, 32'(out_bit), 32'(vecs[i].e));
    end

    // reset after 3rd bit: no partial state survives
    step(0, 0, 1, 4'hF, 0, 0);
    bit_in(1, 0); bit_in(1, 0); bit_in(1, 0);
    #1 reset_n = 1'b0;
    #1 check("rst_mid_out", 32'(out_bit), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    bit_in(1, 0);
    check("rst_no_partial", 32'(out_bit), 0);
    bit_in(1, 0); bit_in(1, 0); bit_in(1, 0);
    check("rst_fresh_hit", 32'(out_bit), 1);
    #1 reset_n = 1'b0;
    #1 check("rst_async_out", 32'(out_bit), 0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();

    // zero pattern after reset with no bits never fires
    step(0, 0, 1, 4'h0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 4'h0, 0, 0);
      check("zero_pat_idle", 32'(out_bit), 0);
    end

`ifdef PATDET_COUNT_EN
    // saturating counter with CNT_W=2
    step(0, 0, 1, 4'hF, 1, 1);
    bit_in(1, 1); bit_in(1, 1); bit_in(1, 1);
    bit_in(1, 1); check("cnt_1", 32'(match_count), 1);
    bit_in(1, 1); check("cnt_2", 32'(match_count), 2);
    bit_in(1, 1); check("cnt_3", 32'(match_count), 3);
    bit_in(1, 1); check("cnt_sat_a", 32'(match_count), 3);
    bit_in(1, 1); check("cnt_sat_b", 32'(match_count), 3);
    step(0, 0, 0, 4'h0, 1, 1);
    check("cnt_clear", 32'(match_count), 0);
`endif

    // randomized run against the queue model
    step(0, 0, 1, 4'($urandom_range(15, 0)), 0, 1);
    for (int i = 0; i < 3000; i++) begin
      logic v, b, ld, ov, cl;
      logic [PAT_LEN-1:0] p;
      v  = ($urandom_range(99, 0) < 75);
      b  = 1'($urandom_range(1, 0));
      ld = ($urandom_range(99, 0) < 3);
      cl = ($urandom_range(99, 0) < 2);
      ov = 1'($urandom_range(1, 0));
      p  = 4'($urandom_range(15, 0));
      step(v, b, ld, p, ov, cl);
      check("rand_out", 32'(out_bit), 32'(m_out));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
